// File: rtl/key_expand_seq.sv
// Sequential AES-128/192/256 key schedule: one expanded word per clock into an
// internal word buffer, round keys read back combinationally by index.
module key_expand_seq #(
  parameter int MAX_KEY_SIZE = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [1:0]              key_len,
  input  logic [MAX_KEY_SIZE-1:0] key,
  output logic                    busy,
  output logic                    done,
  output logic                    keys_valid,
  output logic                    err,
  output logic [3:0]              num_rounds,
  input  logic [3:0]              rk_idx,
  output logic [127:0]            rk_out
);

  localparam int KW    = MAX_KEY_SIZE / 32;
  localparam int DEPTH = (MAX_KEY_SIZE <= 128) ? 44 : (MAX_KEY_SIZE <= 192) ? 52 : 60;

  typedef enum logic {IDLE, GEN} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254, 0 maps to 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] y;
    logic [7:0] r;
    y = gf_mul(b, b);
    r = y;
    for (int k = 0; k < 6; k++) begin
      y = gf_mul(y, y);
      r = gf_mul(r, y);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^
           {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [5:0] nk_of(input logic [1:0] m);
    case (m)
      2'b00:   return 6'd4;
      2'b01:   return 6'd6;
      2'b10:   return 6'd8;
      default: return 6'd0;
    endcase
  endfunction

  function automatic logic [5:0] nw_of(input logic [1:0] m);
    case (m)
      2'b00:   return 6'd44;
      2'b01:   return 6'd52;
      default: return 6'd60;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] m);
    case (m)
      2'b00:   return 4'd10;
      2'b01:   return 4'd12;
      default: return 4'd14;
    endcase
  endfunction

  function automatic logic mode_ok(input logic [1:0] m);
    return (m != 2'b11) && ((128 + 64 * int'(m)) <= MAX_KEY_SIZE);
  endfunction

  state_t      state_q, state_d;
  logic [5:0]  i_q, i_d;
  logic [2:0]  phase_q, phase_d;
  logic [7:0]  rcon_q, rcon_d;
  logic [1:0]  mode_q, mode_d;
  logic [3:0]  nr_q, nr_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        kv_q, kv_d;

  logic [31:0] wbuf_q [DEPTH];
  logic [31:0] prev_q;

  logic        accept;
  logic [5:0]  nk_in, nk_q;
  logic [2:0]  nk_m1;
  logic [31:0] key_last;
  logic [31:0] sw_in, sw_out, t_word, w_new;

  assign accept = (state_q == IDLE) && start && mode_ok(key_len);
  assign nk_in  = nk_of(key_len);
  assign nk_q   = nk_of(mode_q);
  assign nk_m1  = nk_q[2:0] - 3'd1;

  // State register (control only; buffer and previous word carry no reset)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      phase_q <= '0;
      rcon_q  <= 8'h01;
      mode_q  <= '0;
      nr_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      kv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      phase_q <= phase_d;
      rcon_q  <= rcon_d;
      mode_q  <= mode_d;
      nr_q    <= nr_d;
      done_q  <= done_d;
      err_q   <= err_d;
      kv_q    <= kv_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    phase_d = phase_q;
    rcon_d  = rcon_q;
    mode_d  = mode_q;
    nr_d    = nr_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    kv_d    = kv_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (mode_ok(key_len)) begin
            state_d = GEN;
            mode_d  = key_len;
            nr_d    = nr_of(key_len);
            i_d     = nk_in;
            phase_d = 3'd0;
            rcon_d  = 8'h01;
            kv_d    = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      GEN: begin
        i_d     = i_q + 6'd1;
        phase_d = (phase_q == nk_m1) ? 3'd0 : phase_q + 3'd1;
        if (phase_q == 3'd0) rcon_d = xtime(rcon_q);
        if (i_q == nw_of(mode_q) - 6'd1) begin
          state_d = IDLE;
          done_d  = 1'b1;
          kv_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy       = (state_q == GEN);
    done       = done_q;
    err        = err_q;
    keys_valid = kv_q;
    num_rounds = nr_q;
  end

  always_comb begin
    key_last = '0;
    for (int j = 0; j < KW; j++) begin
      if (j == int'(nk_in) - 1) key_last = key[MAX_KEY_SIZE-1-32*j -: 32];
    end
  end

  // Single shared SubWord path; rotation only on the phase-0 word.
  always_comb begin
    sw_in  = (phase_q == 3'd0) ? {prev_q[23:0], prev_q[31:24]} : prev_q;
    sw_out = sub_word(sw_in);
    if (phase_q == 3'd0)
      t_word = sw_out ^ {rcon_q, 24'h000000};
    else if (mode_q == 2'b10 && phase_q == 3'd4)
      t_word = sw_out;
    else
      t_word = prev_q;
    w_new = wbuf_q[i_q - nk_q] ^ t_word;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (accept) begin
        for (int j = 0; j < KW; j++) begin
          if (j < int'(nk_in)) wbuf_q[j] <= key[MAX_KEY_SIZE-1-32*j -: 32];
        end
        prev_q <= key_last;
      end else if (state_q == GEN) begin
        wbuf_q[i_q] <= w_new;
        prev_q      <= w_new;
      end
    end
  end

  logic [5:0] base;
  always_comb begin
    base   = {rk_idx, 2'b00};
    rk_out = '0;
    if (rk_idx <= nr_q)
      rk_out = {wbuf_q[base], wbuf_q[base + 6'd1], wbuf_q[base + 6'd2], wbuf_q[base + 6'd3]};
  end

endmodule

// File: doc/key_expand_seq.md
Name: key_expand_seq

Overview:
- Sequential, runtime-selectable AES key schedule for AES-128, AES-192 and AES-256. Generates one expanded word per clock and stores the full schedule in an internal word buffer.
- Replaces the fully unrolled combinational expansion when area matters. One shared SubWord path (4 sbox instances) is used instead of one per row.
- Sits between key load and the iterative cipher core. The core reads round keys by index through `rk_idx`.

Parameters:
- MAX_KEY_SIZE, 256, largest key size supported (128/192/256). Sets buffer depth: 44/52/60 words. Modes above it are rejected.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request expansion; sampled only in IDLE
- key_len  in  2  00=AES-128, 01=AES-192, 10=AES-256, 11=reserved
- key  in  MAX_KEY_SIZE  cipher key, left-justified (AES-128 key in the top 128 bits); captured on start
- busy  out  1  expansion in progress
- done  out  1  one-cycle pulse when the last word is written
- keys_valid  out  1  buffer holds a complete schedule for the current key_len
- err  out  1  one-cycle pulse: start rejected (reserved or unsupported key_len)
- num_rounds  out  4  10/12/14 for the latched mode; 0 after reset
- rk_idx  in  4  round-key index to read
- rk_out  out  128  {w[4r], w[4r+1], w[4r+2], w[4r+3]}, with w[4r] in the MSBs; combinational read

Behaviour:
- Reset values: state=IDLE; busy=0, done=0, keys_valid=0, err=0, num_rounds=0, rcon=0x01. Buffer contents are not cleared.
- Mode constants:
  - Nk = 4/6/8.
  - Total words Nw = 44/52/60.
  - Rounds = 10/12/14.
- States: IDLE -> GEN -> IDLE.
- IDLE:
  - start=1 with a legal mode (key_len!=11 and key size <= MAX_KEY_SIZE), at edge E0:
    - write w[0..Nk-1] from key (w[0] = key MSB word);
    - latch the mode; set num_rounds;
    - i=Nk, phase=0 (i mod Nk), rcon=0x01;
    - busy=1, keys_valid=0; state=GEN.
  - start=1 with an illegal mode: err=1 for one cycle. No other state changes; keys_valid is kept.
- GEN: each edge writes w[i] = w[i-Nk] XOR t, then i++ and phase wraps at Nk. The term t is:
  - phase==0: t = SubWord(RotWord(w[i-1])) XOR {rcon,24'h0}; then rcon = xtime(rcon) (0x80 -> 0x1B).
  - AES-256 and phase==4: t = SubWord(w[i-1]).
  - otherwise: t = w[i-1].
  - w[i-1] and w[i-Nk] come from the buffer or from a previous-word register. No combinational path from the write to the read is permitted beyond one word.
- Completion: on the edge writing w[Nw-1]:
  - state=IDLE, busy=0;
  - done=1 for the next cycle only;
  - keys_valid=1.
  - Latency from E0 to the done-asserting edge is Nw-Nk edges: 40/46/52.
- start while busy: ignored, no err. key_len and key may change freely after E0.
- Read port:
  - rk_out is valid only while keys_valid=1.
  - rk_idx > num_rounds gives rk_out=0.
  - rk_idx in range while keys_valid=0: the value is don't care.
- rst mid-expansion: abort to IDLE at that edge. All outputs return to reset values; no done pulse.
- rst and start high together: reset wins.
- Back-to-back: start in the cycle done is high is accepted, because the state is already IDLE.

Test Plan:
- AES-128: key 2b7e151628aed2a6abf7158809cf4f3c, start one cycle -> busy for 40 cycles; done pulses once; rk_idx=0 gives the key; rk_idx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6; num_rounds=10.
- AES-192: key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> done after 46 cycles; rk_idx=12 gives e98ba06f448c773c8ecc720401002202; rk_idx=13 gives 0.
- AES-256: key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> done after 52 cycles; rk_idx=14 gives fe4890d1e6188d0b046df344706c631e. This checks the phase-4 SubWord path.
- Protocol:
  - key_len=11 with start -> err pulses once; busy stays 0; previous keys_valid and rk_out are unchanged.
  - start pulsed again at cycle 10 of a run -> ignored; results identical to the first scenario.
- Reset:
  - rst asserted at cycle 20 of an AES-256 run -> next cycle busy=0, keys_valid=0, num_rounds=0, and no done pulse.
  - A following AES-128 run then gives the first scenario's values.
  - A back-to-back start in the done cycle completes correctly.
